// File: rtl/imem_scan_pkg.sv
// Shared types and constants for the instruction-memory scan controller and errordetect.
package imem_scan_pkg;

  localparam int unsigned ERR_W      = 3;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [ERR_W-1:0] ERR_NONE = 3'd0;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone,
    StHalt
  } scan_state_e;

endpackage

// File: rtl/imem_scan_ctrl.sv
// Restartable instruction-memory scan that halts on and records the first faulty word.
// Optional IMEM_SCAN_SKIP_EN: errors are counted and the first one captured, but never halt the scan.
module imem_scan_ctrl
  import imem_scan_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ERR_W-1:0] error,
  input  logic [31:0]      idata,
  output logic [31:0]      iaddr,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic [ERR_W-1:0] err_code,
  output logic [31:0]      err_addr,
  output logic [31:0]      err_instr,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [31:0] LastAddr = RESET_PC + 32'(WORD_BYTES * (DEPTH_WORDS - 1));
  localparam logic [31:0] Step     = 32'(WORD_BYTES);

`ifdef IMEM_SCAN_SKIP_EN
  localparam bit HaltOnError = 1'b0;
`else
  localparam bit HaltOnError = 1'b1;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  scan_state_e      state_q, state_d;
  logic [31:0]      iaddr_q, iaddr_d;
  logic [ERR_W-1:0] err_code_q, err_code_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [31:0]      err_instr_q, err_instr_d;
  logic [CNT_W-1:0] chk_count_q, chk_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      iaddr_q     <= RESET_PC;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= '0;
      err_instr_q <= '0;
      chk_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      iaddr_q     <= iaddr_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
      err_instr_q <= err_instr_d;
      chk_count_q <= chk_count_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    iaddr_d     = iaddr_q;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    err_instr_d = err_instr_q;
    chk_count_d = chk_count_q;
    err_count_d = err_count_q;

    unique case (state_q)
      StIdle, StDone, StHalt: begin
        if (start) begin
          state_d     = StScan;
          iaddr_d     = RESET_PC;
          err_code_d  = ERR_NONE;
          err_addr_d  = '0;
          err_instr_d = '0;
          chk_count_d = '0;
          err_count_d = '0;
        end
      end
      StScan: begin
        chk_count_d = sat_inc(chk_count_q);
        if (error != ERR_NONE) begin
          // Only the first faulty word of a scan is recorded.
          if (err_count_q == '0) begin
            err_code_d  = error;
            err_addr_d  = iaddr_q;
            err_instr_d = idata;
          end
          err_count_d = sat_inc(err_count_q);
        end
        if (HaltOnError && (error != ERR_NONE)) begin
          state_d = StHalt;
        end else if (iaddr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          iaddr_d = iaddr_q + Step;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign iaddr     = iaddr_q;
  assign busy      = (state_q == StScan);
  assign done      = (state_q == StDone);
  assign halted    = (state_q == StHalt);
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;
  assign err_instr = err_instr_q;
  assign chk_count = chk_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imem_scan_ctrl.sv
// Directed bench for imem_scan_ctrl: an 8-word image with injectable faults and a 2-bit-counter copy.
module tb_imem_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [2:0]  error, error2;
  logic [31:0] idata, idata2;
  logic [31:0] iaddr, iaddr2;
  logic        busy, done, halted, busy2, done2, halted2;
  logic [2:0]  err_code, err_code2;
  logic [31:0] err_addr, err_instr, err_addr2, err_instr2;
  logic [15:0] chk_count, err_count;
  logic [1:0]  chk_count2, err_count2;

  logic [2:0]  err_map [8];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return 32'h600D_F00D ^ (a * 32'h0101_0101);
  endfunction

  assign idata  = img(iaddr);
  assign error  = err_map[iaddr[4:2]];
  assign idata2 = img(iaddr2);
  assign error2 = 3'd0;

  imem_scan_ctrl #(.RESET_PC(32'h0), .DEPTH_WORDS(8), .CNT_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .error     (error),
    .idata     (idata),
    .iaddr     (iaddr),
    .busy      (busy),
    .done      (done),
    .halted    (halted),
    .err_code  (err_code),
    .err_addr  (err_addr),
    .err_instr (err_instr),
    .chk_count (chk_count),
    .err_count (err_count)
  );

  imem_scan_ctrl #(.RESET_PC(32'h0), .DEPTH_WORDS(6), .CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .error     (error2),
    .idata     (idata2),
    .iaddr     (iaddr2),
    .busy      (busy2),
    .done      (done2),
    .halted    (halted2),
    .err_code  (err_code2),
    .err_addr  (err_addr2),
    .err_instr (err_instr2),
    .chk_count (chk_count2),
    .err_count (err_count2)
  );

  task automatic clear_faults();
    for (int i = 0; i < 8; i++) err_map[i] = 3'd0;
  endtask

  // Leaves the bench at the negedge after the start edge: DUT is in SCAN at RESET_PC.
  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound && busy; k++) @(negedge clk);
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL scan_timeout: busy=%0b after %0d cycles, want 0", busy, bound);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({iaddr, busy, done, halted, err_code} !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_ctrl: iaddr=%h b/d/h=%b%b%b code=%0d, want all 0",
               iaddr, busy, done, halted, err_code);
    end
    n_cmp++;
    if ({err_addr, err_instr, chk_count, err_count} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_regs: addr=%h instr=%h chk=%0d errs=%0d, want 0",
               err_addr, err_instr, chk_count, err_count);
    end
    n_cmp++;
    if ({busy2, done2, chk_count2} !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_sat: busy=%b done=%b chk=%0d, want 0", busy2, done2, chk_count2);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_scan();
    clear_faults();
    do_start();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (iaddr !== 32'(4 * i) || busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL clean_step%0d: iaddr=%h busy=%b done=%b, want %h 1 0",
                 i, iaddr, busy, done, 4 * i);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({done, busy, halted} !== 3'b100 || iaddr !== 32'h1C) begin
      n_bad++;
      $display("FAIL clean_end: d/b/h=%b%b%b iaddr=%h, want 100 0000001c",
               done, busy, halted, iaddr);
    end
    n_cmp++;
    if (chk_count !== 16'd8 || err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL clean_counts: chk=%0d errs=%0d, want 8 0", chk_count, err_count);
    end
  endtask

  task automatic test_fault_mid();
    clear_faults();
    err_map[3] = 3'd5;
    do_start();
    wait_idle(20);
`ifdef IMEM_SCAN_SKIP_EN
    n_cmp++;
    if ({done, halted} !== 2'b10 || iaddr !== 32'h1C || chk_count !== 16'd8) begin
      n_bad++;
      $display("FAIL mid_state: d/h=%b%b iaddr=%h chk=%0d, want 10 1c 8",
               done, halted, iaddr, chk_count);
    end
`else
    n_cmp++;
    if ({done, halted} !== 2'b01 || iaddr !== 32'h0C || chk_count !== 16'd4) begin
      n_bad++;
      $display("FAIL mid_state: d/h=%b%b iaddr=%h chk=%0d, want 01 0c 4",
               done, halted, iaddr, chk_count);
    end
`endif
    n_cmp++;
    if (err_code !== 3'd5 || err_addr !== 32'h0C || err_instr !== img(32'h0C)) begin
      n_bad++;
      $display("FAIL mid_capture: code=%0d addr=%h instr=%h, want 5 0c %h",
               err_code, err_addr, err_instr, img(32'h0C));
    end
    n_cmp++;
    if (err_count !== 16'd1) begin
      n_bad++;
      $display("FAIL mid_errcount: got %0d want 1", err_count);
    end
    // Captured record must hold steady while parked.
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_addr !== 32'h0C || err_code !== 3'd5) begin
      n_bad++;
      $display("FAIL mid_sticky: addr=%h code=%0d, want 0c 5", err_addr, err_code);
    end
  endtask

  task automatic test_fault_last();
    clear_faults();
    err_map[7] = 3'd3;
    do_start();
    wait_idle(20);
`ifdef IMEM_SCAN_SKIP_EN
    n_cmp++;
    if ({done, halted} !== 2'b10) begin
      n_bad++;
      $display("FAIL last_state: d/h=%b%b want 10", done, halted);
    end
`else
    n_cmp++;
    if ({done, halted} !== 2'b01) begin
      n_bad++;
      $display("FAIL last_state: d/h=%b%b want 01", done, halted);
    end
`endif
    n_cmp++;
    if (err_addr !== 32'h1C || err_code !== 3'd3 || iaddr !== 32'h1C || chk_count !== 16'd8) begin
      n_bad++;
      $display("FAIL last_capture: addr=%h code=%0d iaddr=%h chk=%0d, want 1c 3 1c 8",
               err_addr, err_code, iaddr, chk_count);
    end
  endtask

  task automatic test_restart_and_reset();
    clear_faults();
    do_start();
    n_cmp++;
    if ({err_code, err_addr, err_instr, chk_count, err_count} !== 99'h0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_clear: code=%0d addr=%h instr=%h chk=%0d errs=%0d busy=%b",
               err_code, err_addr, err_instr, chk_count, err_count, busy);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (iaddr !== 32'(4 * i) || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_step%0d: iaddr=%h busy=%b, want %h 1", i, iaddr, busy, 4 * i);
      end
      start = (i == 2);
      reset = (i == 4);
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if ({iaddr, busy, done, halted, chk_count, err_count} !== 67'h0) begin
      n_bad++;
      $display("FAIL midscan_reset: iaddr=%h b/d/h=%b%b%b chk=%0d errs=%0d, want 0",
               iaddr, busy, done, halted, chk_count, err_count);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || iaddr !== 32'h0) begin
      n_bad++;
      $display("FAIL idle_hold: busy=%b iaddr=%h, want 0 0", busy, iaddr);
    end
  endtask

  task automatic test_two_faults();
    clear_faults();
    err_map[1] = 3'd2;
    err_map[5] = 3'd6;
    do_start();
    wait_idle(20);
`ifdef IMEM_SCAN_SKIP_EN
    n_cmp++;
    if ({done, halted} !== 2'b10 || err_count !== 16'd2 || chk_count !== 16'd8) begin
      n_bad++;
      $display("FAIL two_state: d/h=%b%b errs=%0d chk=%0d, want 10 2 8",
               done, halted, err_count, chk_count);
    end
`else
    n_cmp++;
    if ({done, halted} !== 2'b01 || err_count !== 16'd1 || chk_count !== 16'd2) begin
      n_bad++;
      $display("FAIL two_state: d/h=%b%b errs=%0d chk=%0d, want 01 1 2",
               done, halted, err_count, chk_count);
    end
`endif
    n_cmp++;
    if (err_addr !== 32'h04 || err_code !== 3'd2 || err_instr !== img(32'h04)) begin
      n_bad++;
      $display("FAIL two_capture: addr=%h code=%0d instr=%h, want 04 2 %h",
               err_addr, err_code, err_instr, img(32'h04));
    end
  endtask

  task automatic test_saturation();
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int k = 0; k < 20 && busy2; k++) @(negedge clk);
    n_cmp++;
    if ({done2, busy2, halted2} !== 3'b100 || iaddr2 !== 32'h14) begin
      n_bad++;
      $display("FAIL sat_end: d/b/h=%b%b%b iaddr=%h, want 100 14", done2, busy2, halted2, iaddr2);
    end
    n_cmp++;
    if (chk_count2 !== 2'd3 || err_count2 !== 2'd0) begin
      n_bad++;
      $display("FAIL sat_count: chk=%0d errs=%0d, want 3 0", chk_count2, err_count2);
    end
  endtask

  initial begin
    clear_faults();
    test_reset();
    test_clean_scan();
    test_fault_mid();
    test_fault_last();
    test_restart_and_reset();
    test_two_faults();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_scan_ctrl.md
Name: imem_scan_ctrl

Overview:
- Sequencer that walks instruction memory and supervises the error detector.
- Drives iaddr into imem; imem returns idata combinationally; errordetect turns idata into a 3-bit error code.
- This block consumes that code in the same cycle, halts on the first faulty word and captures the fault record.
- Replaces the free-running address counter used at bench level with a controlled, restartable scan.

Parameters:
- RESET_PC, 32'h0000_0000, first word address of the scan (word aligned).
- DEPTH_WORDS, 32, number of 32-bit words scanned; last address = RESET_PC + 4*(DEPTH_WORDS-1).
- CNT_W, 16, width of the checked-word and error counters.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high; dominates every other input.
- start  in  1  one-cycle pulse; begins a scan from RESET_PC.
- error  in  3  errordetect code for current idata; 3'd0 = no error.
- idata  in  32  instruction word at iaddr (combinational imem output).
- iaddr  out  32  current scan address to imem.
- busy  out  1  high while scanning.
- done  out  1  scan reached last address with no halting error.
- halted  out  1  scan stopped on an erroneous word.
- err_code  out  3  captured error code of the first faulty word.
- err_addr  out  32  captured address of the first faulty word.
- err_instr  out  32  captured idata of the first faulty word.
- chk_count  out  CNT_W  words checked in the current or last scan, saturating.
- err_count  out  CNT_W  faulty words seen, saturating.

Behaviour:
- Reset values:
  - iaddr = RESET_PC; state = IDLE.
  - busy, done, halted = 0.
  - err_code = 0, err_addr = 0, err_instr = 0, chk_count = 0, err_count = 0.
- States: IDLE, SCAN, DONE, HALT.
- Outputs: busy = (state==SCAN); done = (state==DONE); halted = (state==HALT); all registered.
- IDLE/DONE/HALT, start=1:
  - iaddr <= RESET_PC; clear all err_* and both counters.
  - Go to SCAN. First word is evaluated in the following cycle.
- SCAN, each posedge evaluates the word currently at iaddr (one word per cycle, zero added latency):
  - chk_count increments.
  - error != 0:
    - If err_count == 0: capture err_code <= error, err_addr <= iaddr, err_instr <= idata.
    - err_count increments.
    - Go to HALT; iaddr holds.
  - Else, iaddr == last address: go to DONE; iaddr holds.
  - Else: iaddr <= iaddr + 4.
- Error on the last address: HALT takes priority over DONE.
- start while in SCAN is ignored.
- reset during SCAN returns to IDLE with reset values on the next edge; captured data is lost.
- Counters saturate at 2^CNT_W-1 and never wrap.
- iaddr never exceeds the last address and never wraps.
- DEPTH_WORDS=1: a single evaluation cycle, then DONE or HALT.
- Captured err_* remain stable in DONE/HALT until the next start or reset.

Optional Feature:
- Macro: IMEM_SCAN_SKIP_EN.
- Defined:
  - An error does not halt; the first error is captured as above (sticky).
  - err_count increments on every faulty word.
  - iaddr keeps advancing; the scan always ends in DONE.
  - halted stays 0; HALT is unreachable.
- Undefined: behaviour as above; err_count is only ever 0 or 1.

Decomposition:
- Shared package imem_scan_pkg:
  - state enum: IDLE, SCAN, DONE, HALT.
  - ERR_NONE = 3'd0.
  - WORD_BYTES = 4.
  - Error-code width constant shared with errordetect.
- No sub-module: a single module with state register, address counter and capture registers. The saturating counter is a local function, not a module.

Test Plan:
- Clean image (all words error-free), DEPTH_WORDS=8, start at cycle 2 -> iaddr steps 0,4,...,28; done=1 exactly 8 cycles after SCAN entry; chk_count=8, err_count=0, halted=0.
- Faulty word at address 0x0C, code 3'd5 -> halted=1 after its cycle, iaddr holds 0x0C, err_code=5, err_addr=0x0C, err_instr equals the imem word; chk_count=4.
- Fault only at the last address 0x1C -> halted=1, done=0, err_addr=0x1C.
- Reset asserted mid-scan at iaddr=0x10 -> next edge iaddr=0, all outputs at reset values; start ignored while busy; a restart from HALT clears err_*.
- IMEM_SCAN_SKIP_EN, faults at 0x04 (code 2) and 0x14 (code 6) -> done=1, halted=0, err_count=2, err_addr=0x04, err_code=2.
- CNT_W=2, 6-word clean scan -> chk_count saturates at 3.
